// File: rtl/floppy_seek_ctrl_if.sv
// Host-side command/result bundle of the floppy seek controller.
// Latency: none (wiring only).
// Backpressure: cmd_valid/cmd_ready handshake; done/err and byte_stb/byte_idx are unthrottled pulses.
interface floppy_seek_ctrl_if;
  logic       cmd_valid;
  logic       cmd_ready;
  logic       cmd_restore;
  logic       cmd_read;
  logic [6:0] cmd_track;
  logic [3:0] cmd_sector;
  logic       done;
  logic [1:0] err;
  logic       byte_stb;
  logic [9:0] byte_idx;

  // FDC register side issues commands and consumes results
  modport master (
    output cmd_valid, cmd_restore, cmd_read, cmd_track, cmd_sector,
    input  cmd_ready, done, err, byte_stb, byte_idx
  );

  // Seek controller side
  modport slave (
    input  cmd_valid, cmd_restore, cmd_read, cmd_track, cmd_sector,
    output cmd_ready, done, err, byte_stb, byte_idx
  );
endinterface

// File: rtl/floppy_seek_ctrl.sv
// Seek/restore/read sequencer between the FDC registers and the floppy drive.
// Latency: accept to done spans spin-up, step/settle per track and sector search (ms scale).
// Backpressure: cmd_ready only in IDLE; byte_stb has no handshake, the datapath must take every byte.
module floppy_seek_ctrl #(
  parameter int SYS_CLK         = 8000000,
  parameter int STEP_PULSE_CLKS = 32,
  parameter int SPINUP_TMO_MS   = 1000,
  parameter int MOTOR_OFF_MS    = 2000,
  parameter int INDEX_RETRIES   = 5,
  parameter int SECTOR_LEN      = 1024,
  parameter int MAX_STEPS       = 85
) (
  input  logic              clk,
  input  logic              reset_n,
  floppy_seek_ctrl_if.slave host,
  output logic              fdd_select,
  output logic              fdd_motor_on,
  output logic              fdd_step_in,
  output logic              fdd_step_out,
  input  logic [6:0]        fdd_track,
  input  logic [3:0]        fdd_sector,
  input  logic              fdd_sector_hdr,
  input  logic              fdd_sector_data,
  input  logic              fdd_dclk_en,
  input  logic              fdd_ready,
  input  logic              fdd_index
);

  localparam int CLK_PER_MS  = SYS_CLK / 1000;
  localparam int SPINUP_CLKS = CLK_PER_MS * SPINUP_TMO_MS;
  localparam int MOTOR_CLKS  = CLK_PER_MS * MOTOR_OFF_MS;
  localparam int TMO_W       = $clog2(SPINUP_CLKS + STEP_PULSE_CLKS + 3);
  localparam int MOT_W       = $clog2(MOTOR_CLKS + 1);
  localparam int STP_W       = $clog2(MAX_STEPS + 2);
  localparam int RTY_W       = $clog2(INDEX_RETRIES + 1);

  typedef enum logic [2:0] {
    S_IDLE, S_SPINUP, S_STEP, S_SETTLE, S_VERIFY, S_HDR_WAIT, S_XFER, S_DONE
  } state_t;

  state_t           state, state_nx;
  logic             restore_q, restore_nx;
  logic             read_q, read_nx;
  logic [6:0]       track_q, track_nx;
  logic [3:0]       sector_q, sector_nx;
  logic [TMO_W-1:0] tmo_q, tmo_nx;
  logic [MOT_W-1:0] mot_q, mot_nx;
  logic [STP_W-1:0] steps_q, steps_nx;
  logic [RTY_W-1:0] retry_q, retry_nx;
  logic [9:0]       byte_q, byte_nx;
  logic             seen_q, seen_nx;
  logic [1:0]       err_q, err_nx;
  logic             motor_q, motor_nx;
  logic             select_q, select_nx;
  logic             step_in_q, step_in_nx;
  logic             step_out_q, step_out_nx;
  logic             stb_q, stb_nx;
  logic [9:0]       stb_idx_q, stb_idx_nx;
  logic             index_prev_q;

  logic       eval_dir;
  logic [6:0] target;
  logic       at_target;
  logic       go_in;
  logic       step_limit;
  logic       index_fall;

  // Restore always heads for track 0 and always steps inward, whatever the head reports
  assign target     = restore_q ? 7'd0 : track_q;
  assign at_target  = (fdd_track == target);
  assign go_in      = restore_q || (track_q < fdd_track);
  assign step_limit = restore_q ? (steps_q >= STP_W'(MAX_STEPS))
                                : (steps_q >  STP_W'(MAX_STEPS));
  assign index_fall = index_prev_q && !fdd_index;

  assign host.cmd_ready = (state == S_IDLE);
  assign host.done      = (state == S_DONE);
  assign host.err       = err_q;
  assign host.byte_stb  = stb_q;
  assign host.byte_idx  = stb_idx_q;
  assign fdd_select     = select_q;
  assign fdd_motor_on   = motor_q;
  assign fdd_step_in    = step_in_q;
  assign fdd_step_out   = step_out_q;

  // Next-state and next-output decode; SPINUP and SETTLE share the direction decision
  always_comb begin
    state_nx    = state;
    restore_nx  = restore_q;
    read_nx     = read_q;
    track_nx    = track_q;
    sector_nx   = sector_q;
    tmo_nx      = tmo_q;
    mot_nx      = mot_q;
    steps_nx    = steps_q;
    retry_nx    = retry_q;
    byte_nx     = byte_q;
    seen_nx     = seen_q;
    err_nx      = err_q;
    motor_nx    = motor_q;
    select_nx   = select_q;
    step_in_nx  = step_in_q;
    step_out_nx = step_out_q;
    stb_nx      = 1'b0;
    stb_idx_nx  = stb_idx_q;
    eval_dir    = 1'b0;

    case (state)
      S_IDLE: begin
        if (host.cmd_valid) begin
          restore_nx = host.cmd_restore;
          read_nx    = host.cmd_read;
          track_nx   = host.cmd_track;
          sector_nx  = host.cmd_sector;
          motor_nx   = 1'b1;
          select_nx  = 1'b1;
          mot_nx     = MOT_W'(MOTOR_CLKS);
          tmo_nx     = '0;
          steps_nx   = '0;
          err_nx     = 2'd0;
          state_nx   = S_SPINUP;
        end else if (motor_q) begin
          // Motor off-timer only runs while the controller sits idle
          if (mot_q <= MOT_W'(1)) begin
            motor_nx  = 1'b0;
            select_nx = 1'b0;
          end else begin
            mot_nx = mot_q - MOT_W'(1);
          end
        end
      end
      S_SPINUP: begin
        if (fdd_ready) begin
          eval_dir = 1'b1;
        end else if (tmo_q == TMO_W'(SPINUP_CLKS - 1)) begin
          err_nx   = 2'd1;
          state_nx = S_DONE;
        end else begin
          tmo_nx = tmo_q + TMO_W'(1);
        end
      end
      S_STEP: begin
        if (tmo_q == TMO_W'(STEP_PULSE_CLKS - 1)) begin
          step_in_nx  = 1'b0;
          step_out_nx = 1'b0;
          steps_nx    = steps_q + STP_W'(1);
          tmo_nx      = '0;
          state_nx    = S_SETTLE;
        end else begin
          tmo_nx = tmo_q + TMO_W'(1);
        end
      end
      S_SETTLE: begin
        // The drive raises busy a cycle after the pulse, so the first two cycles are blind
        if (tmo_q < TMO_W'(2)) begin
          tmo_nx = tmo_q + TMO_W'(1);
        end else if (fdd_ready) begin
          eval_dir = 1'b1;
        end else if (tmo_q == TMO_W'(SPINUP_CLKS + 1)) begin
          err_nx   = 2'd1;
          state_nx = S_DONE;
        end else begin
          tmo_nx = tmo_q + TMO_W'(1);
        end
      end
      S_VERIFY: begin
        if (!at_target) begin
          err_nx   = 2'd2;
          state_nx = S_DONE;
        end else if (read_q) begin
          retry_nx = '0;
          state_nx = S_HDR_WAIT;
        end else begin
          err_nx   = 2'd0;
          state_nx = S_DONE;
        end
      end
      S_HDR_WAIT: begin
        if (fdd_sector_hdr && (fdd_sector == sector_q)) begin
          byte_nx  = '0;
          seen_nx  = 1'b0;
          state_nx = S_XFER;
        end else if (index_fall) begin
          if (retry_q == RTY_W'(INDEX_RETRIES - 1)) begin
            err_nx   = 2'd3;
            state_nx = S_DONE;
          end else begin
            retry_nx = retry_q + RTY_W'(1);
          end
        end
      end
      S_XFER: begin
        // Gap between header and data is legal; a data field that ends short is not
        if (!fdd_ready || (seen_q && !fdd_sector_data)) begin
          err_nx   = 2'd3;
          state_nx = S_DONE;
        end else if (fdd_dclk_en && fdd_sector_data) begin
          stb_nx     = 1'b1;
          stb_idx_nx = byte_q;
          seen_nx    = 1'b1;
          if (byte_q == 10'(SECTOR_LEN - 1)) begin
            err_nx   = 2'd0;
            state_nx = S_DONE;
          end else begin
            byte_nx = byte_q + 10'd1;
          end
        end
      end
      S_DONE: begin
        state_nx = S_IDLE;
      end
      default: begin
        state_nx = S_IDLE;
      end
    endcase

    if (eval_dir) begin
      if (at_target) begin
        state_nx = S_VERIFY;
      end else if (step_limit) begin
        err_nx   = 2'd2;
        state_nx = S_DONE;
      end else begin
        tmo_nx      = '0;
        step_in_nx  = go_in;
        step_out_nx = !go_in;
        state_nx    = S_STEP;
      end
    end
  end

  // State and output registers; reset drops step/motor/select lines immediately
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state        <= S_IDLE;
      restore_q    <= 1'b0;
      read_q       <= 1'b0;
      track_q      <= '0;
      sector_q     <= '0;
      tmo_q        <= '0;
      mot_q        <= '0;
      steps_q      <= '0;
      retry_q      <= '0;
      byte_q       <= '0;
      seen_q       <= 1'b0;
      err_q        <= 2'd0;
      motor_q      <= 1'b0;
      select_q     <= 1'b0;
      step_in_q    <= 1'b0;
      step_out_q   <= 1'b0;
      stb_q        <= 1'b0;
      stb_idx_q    <= '0;
      index_prev_q <= 1'b1;
    end else begin
      state        <= state_nx;
      restore_q    <= restore_nx;
      read_q       <= read_nx;
      track_q      <= track_nx;
      sector_q     <= sector_nx;
      tmo_q        <= tmo_nx;
      mot_q        <= mot_nx;
      steps_q      <= steps_nx;
      retry_q      <= retry_nx;
      byte_q       <= byte_nx;
      seen_q       <= seen_nx;
      err_q        <= err_nx;
      motor_q      <= motor_nx;
      select_q     <= select_nx;
      step_in_q    <= step_in_nx;
      step_out_q   <= step_out_nx;
      stb_q        <= stb_nx;
      stb_idx_q    <= stb_idx_nx;
      index_prev_q <= fdd_index;
    end
  end

endmodule

// File: tb/tb_floppy_seek_ctrl.sv
// Directed bench for floppy_seek_ctrl with a small behavioural drive model.
// Clock scaled to 2 clk per ms so the 1000 ms / 2000 ms timers stay short.
// Drive: 5 sectors per track, 1100-clk slots, index low for 4 clks per revolution.
module tb_floppy_seek_ctrl;

  localparam int SYS_CLK     = 2000;
  localparam int SPINUP_CLKS = 2000;   // 1000 ms * 2 clk/ms
  localparam int MOTOR_CLKS  = 4000;   // 2000 ms * 2 clk/ms
  localparam int SLOT        = 1100;
  localparam int NSEC        = 5;
  localparam int REV         = SLOT * NSEC;

  logic clk = 1'b0;
  logic reset_n = 1'b0;
  always #5 clk = ~clk;

  floppy_seek_ctrl_if bus();

  logic       fdd_select, fdd_motor_on, fdd_step_in, fdd_step_out;
  logic [6:0] fdd_track       = 7'd5;
  logic [3:0] fdd_sector      = 4'd0;
  logic       fdd_sector_hdr  = 1'b0;
  logic       fdd_sector_data = 1'b0;
  logic       fdd_dclk_en     = 1'b0;
  logic       fdd_ready       = 1'b0;
  logic       fdd_index       = 1'b1;

  floppy_seek_ctrl #(.SYS_CLK(SYS_CLK)) dut (
    .clk             (clk),
    .reset_n         (reset_n),
    .host            (bus),
    .fdd_select      (fdd_select),
    .fdd_motor_on    (fdd_motor_on),
    .fdd_step_in     (fdd_step_in),
    .fdd_step_out    (fdd_step_out),
    .fdd_track       (fdd_track),
    .fdd_sector      (fdd_sector),
    .fdd_sector_hdr  (fdd_sector_hdr),
    .fdd_sector_data (fdd_sector_data),
    .fdd_dclk_en     (fdd_dclk_en),
    .fdd_ready       (fdd_ready),
    .fdd_index       (fdd_index)
  );

  int ncomp = 0;
  int nfail = 0;

  logic spin_block = 1'b0;
  int   trk = 5, rot_pos = 0, spin_cnt = 0, busy = 0;
  logic prev_in = 1'b0, prev_out = 1'b0;
  int   w_in = 0, w_out = 0;
  int   in_pulses = 0, out_pulses = 0, width_bad = 0, overlap = 0, early_step = 0;
  int   idx_falls = 0, stb_count = 0, order_bad = 0, exp_idx = 0;

  // Drive model plus line monitors, evaluated on the falling edge
  always @(negedge clk) begin
    if (fdd_step_in && fdd_step_out) overlap++;
    if (fdd_step_in) w_in++;
    else if (prev_in) begin in_pulses++; if (w_in != 32) width_bad++; w_in = 0; end
    if (fdd_step_out) w_out++;
    else if (prev_out) begin out_pulses++; if (w_out != 32) width_bad++; w_out = 0; end
    if (((fdd_step_in && !prev_in) || (fdd_step_out && !prev_out)) && !fdd_ready) early_step++;
    if (bus.byte_stb) begin
      stb_count++;
      if (bus.byte_idx != exp_idx[9:0]) order_bad++;
      exp_idx++;
    end
    if (bus.done || !reset_n) exp_idx = 0;

    if (fdd_step_in && !prev_in) begin if (trk > 0) trk--; busy = 40; end
    else if (fdd_step_out && !prev_out) begin if (trk < 84) trk++; busy = 40; end
    else if (busy > 0) busy--;
    prev_in  = fdd_step_in;
    prev_out = fdd_step_out;
    if (!fdd_motor_on) spin_cnt = 0;
    else if (spin_cnt < 20) spin_cnt++;
    fdd_ready = (spin_cnt >= 20) && !spin_block && (busy == 0);
    fdd_track = trk[6:0];

    rot_pos = (rot_pos == REV - 1) ? 0 : rot_pos + 1;
    if (rot_pos == 0) idx_falls++;
    fdd_index       = (rot_pos >= 4);
    fdd_sector      = 4'(rot_pos / SLOT);
    fdd_sector_hdr  = ((rot_pos % SLOT) >= 10) && ((rot_pos % SLOT) < 14);
    fdd_sector_data = ((rot_pos % SLOT) >= 40) && ((rot_pos % SLOT) < 40 + 1024);
    fdd_dclk_en     = fdd_sector_data;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    ncomp++;
    assert (obs === exp) else begin
      nfail++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic issue(input logic rs, input logic rd, input logic [6:0] t, input logic [3:0] s);
    int n;
    n = 0;
    @(negedge clk);
    while (!bus.cmd_ready && n < 100) begin @(negedge clk); n++; end
    bus.cmd_restore = rs;
    bus.cmd_read    = rd;
    bus.cmd_track   = t;
    bus.cmd_sector  = s;
    bus.cmd_valid   = 1'b1;
    @(posedge clk); #1;
    bus.cmd_valid = 1'b0;
  endtask

  task automatic wait_done(input int limit, output int cyc, output logic ok);
    cyc = 0;
    ok  = 1'b0;
    while (cyc < limit && !ok) begin
      @(posedge clk); #1;
      cyc++;
      if (bus.done) ok = 1'b1;
    end
  endtask

  initial begin
    int   cyc, n;
    logic ok;
    int   b_in, b_out, b_wb, b_es, b_stb, b_ob, b_if;

    bus.cmd_valid = 1'b0; bus.cmd_restore = 1'b0; bus.cmd_read = 1'b0;
    bus.cmd_track = 7'd0; bus.cmd_sector = 4'd0;

    // Reset values
    repeat (3) @(posedge clk); #1;
    check("rst_cmd_ready", bus.cmd_ready, 1);
    check("rst_done", bus.done, 0);
    check("rst_err", bus.err, 0);
    check("rst_byte_stb", bus.byte_stb, 0);
    check("rst_select", fdd_select, 0);
    check("rst_motor", fdd_motor_on, 0);
    check("rst_steps", {fdd_step_in, fdd_step_out}, 0);
    @(negedge clk); reset_n = 1'b1;

    // Restore from track 5
    b_in = in_pulses; b_out = out_pulses; b_wb = width_bad;
    issue(1'b1, 1'b0, 7'd0, 4'd0);
    check("busy_cmd_ready", bus.cmd_ready, 0);
    check("accept_select", fdd_select, 1);
    wait_done(5000, cyc, ok);
    check("restore_done", ok, 1);
    check("restore_err", bus.err, 0);
    check("restore_select_at_done", fdd_select, 1);
    check("restore_in_pulses", in_pulses - b_in, 5);
    check("restore_out_pulses", out_pulses - b_out, 0);
    check("restore_width", width_bad - b_wb, 0);
    check("restore_track", fdd_track, 0);

    // Seek 0 -> 10 without read
    b_in = in_pulses; b_out = out_pulses; b_wb = width_bad; b_es = early_step;
    issue(1'b0, 1'b0, 7'd10, 4'd0);
    wait_done(5000, cyc, ok);
    check("seek_done", ok, 1);
    check("seek_err", bus.err, 0);
    check("seek_out_pulses", out_pulses - b_out, 10);
    check("seek_in_pulses", in_pulses - b_in, 0);
    check("seek_width", width_bad - b_wb, 0);
    check("seek_step_before_ready", early_step - b_es, 0);
    check("seek_track", fdd_track, 10);

    // Read track 2 sector 3
    b_in = in_pulses; b_stb = stb_count; b_ob = order_bad;
    issue(1'b0, 1'b1, 7'd2, 4'd3);
    wait_done(12000, cyc, ok);
    check("read_done", ok, 1);
    check("read_err", bus.err, 0);
    check("read_last_stb", bus.byte_stb, 1);
    check("read_last_idx", bus.byte_idx, 1023);
    @(negedge clk); #1;
    check("read_in_pulses", in_pulses - b_in, 8);
    check("read_stb_count", stb_count - b_stb, 1024);
    check("read_idx_order", order_bad - b_ob, 0);
    check("read_overlap", overlap, 0);

    // Sector 9 does not exist on a 5-sector track
    n = 0;
    while (rot_pos != 99 && n < REV + 10) begin @(negedge clk); n++; end
    b_stb = stb_count; b_if = idx_falls;
    issue(1'b0, 1'b1, 7'd2, 4'd9);
    wait_done(40000, cyc, ok);
    check("nf_done", ok, 1);
    check("nf_err", bus.err, 3);
    check("nf_index_edges", idx_falls - b_if, 5);
    @(negedge clk); #1;
    check("nf_stb_count", stb_count - b_stb, 0);

    // Motor off-timer: IDLE entered one cycle after done
    repeat (MOTOR_CLKS) @(posedge clk); #1;
    check("motor_still_on", fdd_motor_on, 1);
    @(posedge clk); #1;
    check("motor_off", fdd_motor_on, 0);
    check("select_off", fdd_select, 0);

    // Drive never becomes ready
    spin_block = 1'b1;
    issue(1'b0, 1'b0, 7'd3, 4'd0);
    check("tmo_motor_on", fdd_motor_on, 1);
    check("tmo_select", fdd_select, 1);
    wait_done(SPINUP_CLKS + 100, cyc, ok);
    check("tmo_done", ok, 1);
    check("tmo_cycles", cyc, SPINUP_CLKS);
    check("tmo_err", bus.err, 1);
    spin_block = 1'b0;

    // Reset in the middle of a sector transfer, then read again
    b_stb = stb_count;
    issue(1'b0, 1'b1, 7'd2, 4'd3);
    n = 0;
    while ((stb_count - b_stb) < 500 && n < 12000) begin @(posedge clk); #1; n++; end
    check("xfer_reached_500", ((stb_count - b_stb) >= 500), 1);
    reset_n = 1'b0;
    #1;
    check("arst_byte_stb", bus.byte_stb, 0);
    check("arst_motor", fdd_motor_on, 0);
    check("arst_select", fdd_select, 0);
    check("arst_cmd_ready", bus.cmd_ready, 1);
    repeat (3) @(negedge clk);
    reset_n = 1'b1;
    b_stb = stb_count;
    repeat (10) @(posedge clk); #1;
    check("post_rst_no_stb", stb_count - b_stb, 0);
    b_stb = stb_count; b_ob = order_bad;
    issue(1'b0, 1'b1, 7'd2, 4'd3);
    wait_done(12000, cyc, ok);
    check("reread_done", ok, 1);
    check("reread_err", bus.err, 0);
    @(negedge clk); #1;
    check("reread_stb_count", stb_count - b_stb, 1024);
    check("reread_idx_order", order_bad - b_ob, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncomp, nfail);
    $finish;
  end

endmodule
